// File: rtl/axi4_write_cmd_queue_if.sv
// Bundle of the command, write-issue and status signals of the write command queue.
// The slave view belongs to the queue; the master view drives it.
// Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready, and a write
// issues on a cycle where write_start && write_ready. A valid side holds its payload
// stable until the transfer, and ready never depends combinationally on valid.
interface axi4_write_cmd_queue_if #(
    parameter int P_ADDR_WIDTH      = 32,
    parameter int P_DATA_WIDTH      = 256,
    parameter int P_DEPTH           = 8,
    parameter int P_MAX_OUTSTANDING = 4
);
    localparam int LEVEL_W = $clog2(P_DEPTH) + 1;
    localparam int OUTST_W = $clog2(P_MAX_OUTSTANDING) + 1;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [P_ADDR_WIDTH-1:0] cmd_addr;
    logic [P_DATA_WIDTH-1:0] cmd_data;
    logic                    drain;
    logic                    drained;
    logic                    write_start;
    logic [P_ADDR_WIDTH-1:0] write_addr;
    logic [P_DATA_WIDTH-1:0] write_data;
    logic                    write_ready;
    logic                    write_done;
    logic                    write_error;
    logic [LEVEL_W-1:0]      level;
    logic [OUTST_W-1:0]      outstanding;
    logic [15:0]             err_count;
    logic                    dbg_state;   // 0 = RUN, 1 = DRAIN

    modport master (
        output cmd_valid, cmd_addr, cmd_data, drain, write_ready, write_done, write_error,
        input  cmd_ready, drained, write_start, write_addr, write_data, level, outstanding,
               err_count, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data, drain, write_ready, write_done, write_error,
        output cmd_ready, drained, write_start, write_addr, write_data, level, outstanding,
               err_count, dbg_state
    );
endinterface

// File: rtl/axi4_write_cmd_queue.sv
// Write command queue: buffers address/data commands in a FIFO, issues them to an
// AXI4 write master while limiting issued-but-not-completed writes, counts error
// completions, and supports a drain request that stops intake and waits for idle.
module axi4_write_cmd_queue #(
    parameter int P_ADDR_WIDTH      = 32,
    parameter int P_DATA_WIDTH      = 256,
    parameter int P_DEPTH           = 8,
    parameter int P_MAX_OUTSTANDING = 4
) (
    input logic                   clock,
    input logic                   reset,
    axi4_write_cmd_queue_if.slave bus
);
    localparam int PTR_W   = $clog2(P_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam int OUTST_W = $clog2(P_MAX_OUTSTANDING) + 1;
    localparam int ENTRY_W = P_ADDR_WIDTH + P_DATA_WIDTH;
    localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(P_DEPTH);
    localparam logic [OUTST_W-1:0] MAXO_L  = OUTST_W'(P_MAX_OUTSTANDING);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ENTRY_W-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level_q;
    logic [OUTST_W-1:0] outst_q;
    logic [15:0]        err_q;
    logic               empty;
    logic               idle;
    logic               push;
    logic               pop;
    logic               done_ok;
    logic [ENTRY_W-1:0] head;

    assign empty   = (level_q == '0);
    assign idle    = empty && (outst_q == '0);
    assign push    = bus.cmd_valid && bus.cmd_ready;
    assign pop     = bus.write_start && bus.write_ready;
    // A completion with nothing in flight is spurious and must not underflow the count.
    assign done_ok = bus.write_done && (outst_q != '0);

    // The head is forced to zero while empty so the bus never shows stale entries.
    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.cmd_ready   = (level_q < DEPTH_L) && (state == RUN);
    assign bus.write_start = !empty && (outst_q < MAXO_L);
    assign bus.write_addr  = head[ENTRY_W-1:P_DATA_WIDTH];
    assign bus.write_data  = head[P_DATA_WIDTH-1:0];
    assign bus.drained     = (state == DRAIN) && idle;
    assign bus.level       = level_q;
    assign bus.outstanding = outst_q;
    assign bus.err_count   = err_q;
    assign bus.dbg_state   = state;

    // FIFO storage; entries need no reset because the head is masked while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_addr, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Issued-but-not-completed write count.
    always_ff @(posedge clock) begin
        if (reset) begin
            outst_q <= '0;
        end else begin
            case ({pop, done_ok})
                2'b10:   outst_q <= outst_q + OUTST_W'(1);
                2'b01:   outst_q <= outst_q - OUTST_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Saturating error completion counter; counts spurious completions too.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else if (bus.write_done && bus.write_error && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next state: leave DRAIN on the cycle the drained pulse is shown.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.drain) state_nxt = DRAIN;
            DRAIN:   if (idle)      state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_axi4_write_cmd_queue.sv
// Directed bench for the write command queue with a queue-based reference model
// checked every cycle, plus hand-computed literal checks at key points.
module tb_axi4_write_cmd_queue;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int DEPTH   = 8;
    localparam int MAXO    = 4;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    axi4_write_cmd_queue_if #(
        .P_ADDR_WIDTH(ADDR_W), .P_DATA_WIDTH(DATA_W),
        .P_DEPTH(DEPTH), .P_MAX_OUTSTANDING(MAXO)
    ) bus ();

    axi4_write_cmd_queue #(
        .P_ADDR_WIDTH(ADDR_W), .P_DATA_WIDTH(DATA_W),
        .P_DEPTH(DEPTH), .P_MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ENTRY_W-1:0] exp_q[$];
    int m_out   = 0;
    int m_err   = 0;
    bit m_drain = 1'b0;
    bit model_valid = 1'b0;

    // Compare process: on each falling edge check outputs against the model, then
    // advance the model with the inputs the next rising edge will sample.
    initial begin
        int lvl;
        bit e_ready, e_start, e_drained, push, pop, done_ok;
        logic [ENTRY_W-1:0] e_head;
        forever begin
            @(negedge clk);
            lvl       = exp_q.size();
            e_ready   = (lvl < DEPTH) && !m_drain;
            e_start   = (lvl != 0) && (m_out < MAXO);
            e_head    = (lvl != 0) ? exp_q[0] : '0;
            e_drained = m_drain && (lvl == 0) && (m_out == 0);
            if (model_valid) begin
                check("m_cmd_ready", bus.cmd_ready, e_ready);
                check("m_write_start", bus.write_start, e_start);
                check("m_write_addr", bus.write_addr, e_head[ENTRY_W-1:DATA_W]);
                check("m_write_data", bus.write_data, e_head[DATA_W-1:0]);
                check("m_level", bus.level, lvl);
                check("m_outstanding", bus.outstanding, m_out);
                check("m_err_count", bus.err_count, m_err);
                check("m_drained", bus.drained, e_drained);
                check("m_state", bus.dbg_state, m_drain);
            end
            if (rst) begin
                exp_q.delete();
                m_out = 0;
                m_err = 0;
                m_drain = 1'b0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                push    = bus.cmd_valid && e_ready;
                pop     = e_start && bus.write_ready;
                done_ok = bus.write_done && (m_out > 0);
                if (bus.write_done && bus.write_error && m_err < 65535) m_err++;
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back({bus.cmd_addr, bus.cmd_data});
                m_out = m_out + int'(pop) - int'(done_ok);
                if (!m_drain) m_drain = bus.drain;
                else if (e_drained) m_drain = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.cmd_valid = v;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        set_cmd(1'b0, '0, '0);
        bus.drain = 1'b0;
        bus.write_ready = 1'b0;
        bus.write_done = 1'b0;
        bus.write_error = 1'b0;
        repeat (3) tick();
        check("rst_level", bus.level, 0);
        check("rst_outstanding", bus.outstanding, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_start", bus.write_start, 0);
        check("rst_drained", bus.drained, 0);
        check("rst_addr", bus.write_addr, 0);
        check("rst_data", bus.write_data, 0);
        rst = 1'b0;
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 1);

        // Two commands, master always ready: issue in cycles N+1 and N+2.
        bus.write_ready = 1'b1;
        set_cmd(1'b1, 32'h00, 256'hF1);
        check("t1_start_pre", bus.write_start, 0);
        tick();
        check("t1_start_n1", bus.write_start, 1);
        check("t1_addr_n1", bus.write_addr, 32'h00);
        check("t1_data_n1", bus.write_data, 256'hF1);
        set_cmd(1'b1, 32'h20, 256'hF2);
        tick();
        check("t1_start_n2", bus.write_start, 1);
        check("t1_addr_n2", bus.write_addr, 32'h20);
        check("t1_data_n2", bus.write_data, 256'hF2);
        check("t1_outst_1", bus.outstanding, 1);
        set_cmd(1'b0, '0, '0);
        tick();
        check("t1_outst_2", bus.outstanding, 2);
        check("t1_start_end", bus.write_start, 0);
        bus.write_ready = 1'b0;
        bus.write_done = 1'b1;
        tick();
        check("t1_outst_after1", bus.outstanding, 1);
        tick();
        bus.write_done = 1'b0;
        check("t1_outst_after2", bus.outstanding, 0);

        // Fill to full with the master stalled; the 9th command is refused.
        for (int i = 0; i < DEPTH; i++) begin
            set_cmd(1'b1, 32'h100 + 32'(i * 4), 256'hA0 + 256'(i));
            tick();
            check("t2_head_hold", bus.write_addr, 32'h100);
        end
        check("t2_level_full", bus.level, 8);
        check("t2_ready_full", bus.cmd_ready, 0);
        set_cmd(1'b1, 32'h999, 256'h99);
        tick();
        set_cmd(1'b0, '0, '0);
        check("t2_level_9th", bus.level, 8);
        check("t2_head_9th", bus.write_addr, 32'h100);
        check("t2_data_9th", bus.write_data, 256'hA0);
        bus.write_ready = 1'b1;
        bus.write_done = 1'b1;
        repeat (8) tick();
        check("t2_level_empty", bus.level, 0);
        check("t2_outst_1", bus.outstanding, 1);
        tick();
        check("t2_outst_0", bus.outstanding, 0);
        bus.write_done = 1'b0;

        // Six commands, no completions: the outstanding limit stops the 5th issue.
        for (int i = 0; i < 6; i++) begin
            set_cmd(1'b1, 32'h200 + 32'(i * 16), 256'hB0 + 256'(i));
            tick();
        end
        set_cmd(1'b0, '0, '0);
        check("t3_level", bus.level, 2);
        check("t3_outst", bus.outstanding, 4);
        check("t3_start_blocked", bus.write_start, 0);
        check("t3_head", bus.write_addr, 32'h240);
        repeat (2) tick();
        check("t3_still_blocked", bus.write_start, 0);
        bus.write_done = 1'b1;
        tick();
        bus.write_done = 1'b0;
        check("t3_release", bus.write_start, 1);
        check("t3_release_addr", bus.write_addr, 32'h240);
        tick();
        check("t3_reblocked", bus.write_start, 0);
        check("t3_next_head", bus.write_addr, 32'h250);
        bus.write_ready = 1'b0;

        // Completions with one error, then spurious completions at zero outstanding.
        bus.write_done = 1'b1;
        tick();
        bus.write_error = 1'b1;
        tick();
        bus.write_error = 1'b0;
        tick();
        check("t4_err_1", bus.err_count, 1);
        check("t4_outst_1", bus.outstanding, 1);
        tick();
        tick();
        check("t4_outst_floor", bus.outstanding, 0);
        bus.write_error = 1'b1;
        tick();
        check("t4_err_spurious", bus.err_count, 2);
        check("t4_outst_spurious", bus.outstanding, 0);
        bus.write_done = 1'b0;
        bus.write_error = 1'b0;
        bus.write_ready = 1'b1;
        tick();
        bus.write_ready = 1'b0;
        bus.write_done = 1'b1;
        tick();
        bus.write_done = 1'b0;

        // Drain with three queued commands; intake refused during the drain.
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 32'h300 + 32'(i * 4), 256'hC0 + 256'(i));
            tick();
        end
        set_cmd(1'b0, '0, '0);
        check("t5_level", bus.level, 3);
        bus.drain = 1'b1;
        tick();
        check("t5_ready_drain", bus.cmd_ready, 0);
        check("t5_drained_early", bus.drained, 0);
        set_cmd(1'b1, 32'h3FC, 256'hEE);
        bus.write_ready = 1'b1;
        repeat (3) tick();
        check("t5_level_0", bus.level, 0);
        check("t5_outst_3", bus.outstanding, 3);
        bus.write_ready = 1'b0;
        bus.write_done = 1'b1;
        repeat (2) tick();
        check("t5_not_yet", bus.drained, 0);
        tick();
        bus.write_done = 1'b0;
        check("t5_drained", bus.drained, 1);
        bus.drain = 1'b0;
        set_cmd(1'b0, '0, '0);
        tick();
        check("t5_drained_once", bus.drained, 0);
        check("t5_ready_back", bus.cmd_ready, 1);

        // Drain while already idle: pulse one cycle after entering DRAIN.
        bus.drain = 1'b1;
        check("t6_pre", bus.drained, 0);
        tick();
        check("t6_drained", bus.drained, 1);
        bus.drain = 1'b0;
        tick();
        check("t6_after", bus.drained, 0);
        check("t6_ready", bus.cmd_ready, 1);

        // Reset mid-operation with LEVEL=5 and OUTSTANDING=3.
        bus.write_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 32'h400 + 32'(i * 4), 256'hD0 + 256'(i));
            tick();
        end
        set_cmd(1'b0, '0, '0);
        tick();
        bus.write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 32'h500 + 32'(i * 4), 256'hE0 + 256'(i));
            tick();
        end
        set_cmd(1'b0, '0, '0);
        check("t7_level", bus.level, 5);
        check("t7_outst", bus.outstanding, 3);
        rst = 1'b1;
        tick();
        check("t7_level_rst", bus.level, 0);
        check("t7_outst_rst", bus.outstanding, 0);
        check("t7_err_rst", bus.err_count, 0);
        check("t7_start_rst", bus.write_start, 0);
        check("t7_addr_rst", bus.write_addr, 0);
        rst = 1'b0;
        tick();
        check("t7_ready", bus.cmd_ready, 1);
        repeat (2) tick();

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
